hsv_mode_exec: RTL and testbench
================================

// Module: hsv_mode_exec
// PURPOSE
//  - Consumer of the 4-bit mode code `sost` (0..6) from the button mode selector.
//  - Executes the per-mode colour action and maintains working Hue/Saturation/Value.
//  - Publishes HSV snapshots to the downstream HSV->RGB/PWM stage over a valid/ready handshake.
//  - One clock domain. Sits between the mode selector and the LED colour pipeline.
// PARAMETERS
//  STEP_DIV    5000000  clk cycles per step tick (0.5 s at 10 MHz); legal range 2..2^27-1
//  HUE_INIT    120      hue loaded at reset and on mode-0 entry; legal range 0..359
//  SV_PRESET   50       sat/val forced on mode-6 entry; legal range 0..100
// PORTS
//  clk        in   1  system clock
//  reset_n    in   1  asynchronous active-low reset
//  sost       in   4  mode code from the mode selector
//  h_in       in   9  external hue (mode 3)
//  s_in       in   7  external saturation (mode 5)
//  v_in       in   7  external value (mode 4)
//  hue        out  9  published hue, 0..359
//  sat        out  7  published saturation, 0..100
//  val        out  7  published value, 0..100
//  hsv_valid  out  1  published snapshot is valid
//  hsv_ready  in   1  downstream accepts snapshot
//  mode_err   out  1  sost > 6 is currently registered
// BEHAVIOUR
//  - Reset (async, reset_n=0):
//    - working and published registers: hue=HUE_INIT, sat=100, val=100.
//    - hsv_valid=0, mode_err=0, sost_q=0, prescaler=0, pending=1.
//    - Result: the reset colour is published on the first clock after release.
//  - Mode register:
//    - sost_q <= sost every cycle.
//    - entry = (sost != sost_q). The entry action executes on that edge, using the new sost.
//  - Prescaler:
//    - Counts 0..STEP_DIV-1; tick=1 on the cycle the count equals STEP_DIV-1, then the count wraps to 0.
//    - Cleared to 0 on entry, so the first tick after entry is STEP_DIV cycles later.
//    - entry and tick in the same cycle: entry action only; the tick is dropped.
//  - Mode actions (working registers change on the action edge):
//    - 0 (entry): hue=HUE_INIT.
//    - 1 (each tick): hue=(hue+60) mod 360. 300 -> 0; 330 -> 30.
//    - 2 (each tick): hue=(hue+1) mod 360. 359 -> 0.
//    - 3 (entry and each tick): hue=min(h_in,359).
//    - 4 (entry and each tick): val=min(v_in,100).
//    - 5 (entry and each tick): sat=min(s_in,100).
//    - 6 (entry): sat=SV_PRESET, val=SV_PRESET.
//    - 7..15: no action, working registers hold, mode_err=1. mode_err=0 when sost_q <= 6.
//  - Arithmetic:
//    - Hue add done at 10 bits; subtract 360 when result >= 360.
//    - Inputs are clamped, never wrapped.
//  - Publish/handshake:
//    - pending is set on any action edge whose result differs from the current working value.
//    - Load edge: pending=1 and (hsv_valid=0 or hsv_ready=1).
//      - On a load edge: published regs <= working regs, hsv_valid <= 1, pending <= 0.
//    - hsv_valid=1 with hsv_ready=0: hue/sat/val are held stable.
//      - Working registers keep updating; only the latest value is published. Intermediate values are coalesced.
//    - hsv_ready=1 with no pending: hsv_valid <= 0.
//    - Latency: action edge -> hsv_valid=1 on the next edge, when the output is free.
//  - Reset mid-operation:
//    - All state returns to reset values immediately.
//    - An in-flight snapshot is dropped; hsv_valid falls asynchronously.
// CONFIGURATION
//  - SOST_SYNC_EN defined:
//    - sost passes through a 2-flop synchroniser (reset 0) before sost_q.
//    - Entry detection is 2 cycles later.
//  - SOST_SYNC_EN undefined:
//    - sost goes directly into sost_q. sost must be synchronous to clk.
// TESTING  (bench: STEP_DIV=4, hsv_ready=1 unless stated)
//  - Reset release, sost=0 -> next edge hsv_valid=1, hue=120, sat=100, val=100; next edge hsv_valid=0.
//  - sost=1 held for 6 ticks -> published hues 180,240,300,0,60,120.
//  - sost=2, hue preset 358 -> 359, 0, 1 on successive ticks. No snapshot appears between ticks.
//  - sost=3, h_in=400 -> hue=359 one edge after entry.
//    - Then sost=5, s_in=127 -> sat=100.
//    - Then sost=6 -> sat=50, val=50.
//  - sost=2 with hsv_ready=0 for 3 ticks -> hue frozen at the first snapshot.
//    - ready=1 -> next snapshot is the latest working hue (coalesced).
//  - sost=9 -> mode_err=1 and outputs hold. sost=1 -> mode_err=0.
//    - reset_n pulse mid-tick -> hue=120 and hsv_valid=0 immediately.

Source files
------------

// File: rtl/hsv_mode_exec.sv
// Mode executor: applies the per-mode colour action to working H/S/V and publishes snapshots over valid/ready.
// Optional define SOST_SYNC_EN inserts a 2-flop synchroniser on sost ahead of the mode register.
module hsv_mode_exec #(
    parameter int STEP_DIV  = 5000000,
    parameter int HUE_INIT  = 120,
    parameter int SV_PRESET = 50
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] sost,
    input  logic [8:0] h_in,
    input  logic [6:0] s_in,
    input  logic [6:0] v_in,
    output logic [8:0] hue,
    output logic [6:0] sat,
    output logic [6:0] val,
    output logic       hsv_valid,
    input  logic       hsv_ready,
    output logic       mode_err
);
    localparam int            CW       = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(STEP_DIV - 1);
    localparam logic [8:0]    HUE_RST  = 9'(HUE_INIT);
    localparam logic [6:0]    SV_RST   = 7'(SV_PRESET);

    logic [3:0]    sost_s;
    logic [3:0]    sost_q_reg;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [8:0]    hue_w_reg, hue_w_next;
    logic [6:0]    sat_w_reg, sat_w_next;
    logic [6:0]    val_w_reg, val_w_next;
    logic [8:0]    hue_reg;
    logic [6:0]    sat_reg, val_reg;
    logic          valid_reg, valid_next;
    logic          pending_reg, pending_next;
    logic          entry, tick, changed, load;
    logic [9:0]    sum60, sum1;
    logic [8:0]    hue_p60, hue_p1, h_clamp;
    logic [6:0]    s_clamp, v_clamp;

`ifdef SOST_SYNC_EN
    logic [3:0] sync1_reg, sync2_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= sost;
            sync2_reg <= sync1_reg;
        end
    end
    assign sost_s = sync2_reg;
`else
    assign sost_s = sost;
`endif

    // Entry wins over a coincident tick: the count restarts and the tick is lost.
    assign entry    = (sost_s != sost_q_reg);
    assign tick     = (cnt_reg == CNT_LAST) && !entry;
    assign cnt_next = (entry || (cnt_reg == CNT_LAST)) ? '0 : cnt_reg + CW'(1);

    assign sum60   = {1'b0, hue_w_reg} + 10'd60;
    assign sum1    = {1'b0, hue_w_reg} + 10'd1;
    assign hue_p60 = (sum60 >= 10'd360) ? 9'(sum60 - 10'd360) : sum60[8:0];
    assign hue_p1  = (sum1 >= 10'd360) ? 9'(sum1 - 10'd360) : sum1[8:0];
    assign h_clamp = (h_in > 9'd359) ? 9'd359 : h_in;
    assign s_clamp = (s_in > 7'd100) ? 7'd100 : s_in;
    assign v_clamp = (v_in > 7'd100) ? 7'd100 : v_in;

    always_comb begin
        hue_w_next = hue_w_reg;
        sat_w_next = sat_w_reg;
        val_w_next = val_w_reg;
        case (sost_s)
            4'd0: if (entry) hue_w_next = HUE_RST;
            4'd1: if (tick) hue_w_next = hue_p60;
            4'd2: if (tick) hue_w_next = hue_p1;
            4'd3: if (entry || tick) hue_w_next = h_clamp;
            4'd4: if (entry || tick) val_w_next = v_clamp;
            4'd5: if (entry || tick) sat_w_next = s_clamp;
            4'd6: if (entry) begin
                sat_w_next = SV_RST;
                val_w_next = SV_RST;
            end
            default: ;
        endcase
    end

    // A load publishes the pre-edge working value; a same-edge change re-arms pending.
    assign changed      = (hue_w_next != hue_w_reg) || (sat_w_next != sat_w_reg) ||
                          (val_w_next != val_w_reg);
    assign load         = pending_reg && (!valid_reg || hsv_ready);
    assign pending_next = changed || (pending_reg && !load);
    assign valid_next   = load ? 1'b1 : (hsv_ready ? 1'b0 : valid_reg);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sost_q_reg  <= '0;
            cnt_reg     <= '0;
            hue_w_reg   <= HUE_RST;
            sat_w_reg   <= 7'd100;
            val_w_reg   <= 7'd100;
            hue_reg     <= HUE_RST;
            sat_reg     <= 7'd100;
            val_reg     <= 7'd100;
            valid_reg   <= 1'b0;
            pending_reg <= 1'b1;
        end else begin
            sost_q_reg  <= sost_s;
            cnt_reg     <= cnt_next;
            hue_w_reg   <= hue_w_next;
            sat_w_reg   <= sat_w_next;
            val_w_reg   <= val_w_next;
            valid_reg   <= valid_next;
            pending_reg <= pending_next;
            if (load) begin
                hue_reg <= hue_w_reg;
                sat_reg <= sat_w_reg;
                val_reg <= val_w_reg;
            end
        end
    end

    assign hue       = hue_reg;
    assign sat       = sat_reg;
    assign val       = val_reg;
    assign hsv_valid = valid_reg;
    assign mode_err  = (sost_q_reg > 4'd6);
endmodule

// File: tb/tb_hsv_mode_exec.sv
// Directed bench for hsv_mode_exec (STEP_DIV=4): vector table for mode entries, loops for tick-driven modes.
module tb_hsv_mode_exec;
    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] sost = '0;
    logic [8:0] h_in = '0;
    logic [6:0] s_in = '0;
    logic [6:0] v_in = '0;
    logic       hsv_ready = 1'b1;
    logic [8:0] hue;
    logic [6:0] sat, val;
    logic       hsv_valid, mode_err;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [3:0] sost;
        logic [8:0] h;
        logic [6:0] s;
        logic [6:0] v;
        logic       rdy;
        logic       exp_valid;
        logic [8:0] exp_hue;
        logic [6:0] exp_sat;
        logic [6:0] exp_val;
        logic       exp_err;
    } vec_t;

    vec_t       vq[$];
    logic [8:0] exp_h[6];

    hsv_mode_exec #(.STEP_DIV(4), .HUE_INIT(120), .SV_PRESET(50)) dut (
        .clk(clk), .reset_n(reset_n), .sost(sost), .h_in(h_in), .s_in(s_in), .v_in(v_in),
        .hue(hue), .sat(sat), .val(val), .hsv_valid(hsv_valid), .hsv_ready(hsv_ready),
        .mode_err(mode_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

    task automatic chk(input string name, input logic ev, input logic [8:0] eh,
                       input logic [6:0] es, input logic [6:0] evl, input logic ee);
        total++;
        if (hsv_valid === ev && hue === eh && sat === es && val === evl && mode_err === ee) begin
            passed++;
            $display("ok   %s valid=%0b hue=%0d sat=%0d val=%0d err=%0b", name, hsv_valid, hue, sat, val, mode_err);
        end else begin
            $display("FAIL %s got valid=%0b hue=%0d sat=%0d val=%0d err=%0b, expected valid=%0b hue=%0d sat=%0d val=%0d err=%0b",
                     name, hsv_valid, hue, sat, val, mode_err, ev, eh, es, evl, ee);
        end
    endtask

    task automatic step(input logic [3:0] s, input logic [8:0] h, input logic [6:0] sv,
                        input logic [6:0] v, input logic r);
        @(negedge clk);
        sost = s; h_in = h; s_in = sv; v_in = v; hsv_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic addv(input logic [3:0] s, input logic [8:0] h, input logic [6:0] sv,
                        input logic [6:0] v, input logic r, input logic ev, input logic [8:0] eh,
                        input logic [6:0] es, input logic [6:0] evl, input logic ee);
        vec_t t;
        t = '{s, h, sv, v, r, ev, eh, es, evl, ee};
        vq.push_back(t);
    endtask

    // Entry edge plus four quiet edges, then per tick: one snapshot edge and three quiet edges.
    task automatic mode_ticks(input logic [3:0] s, input logic [8:0] prev, input int n);
        for (int c = 0; c < 5; c++) begin
            step(s, h_in, s_in, v_in, 1'b1);
            chk($sformatf("m%0d_pre%0d", s, c), 1'b0, prev, 7'd50, 7'd50, 1'b0);
        end
        for (int t = 0; t < n; t++) begin
            step(s, h_in, s_in, v_in, 1'b1);
            chk($sformatf("m%0d_snap%0d", s, t), 1'b1, exp_h[t], 7'd50, 7'd50, 1'b0);
            for (int c = 0; c < 3; c++) begin
                step(s, h_in, s_in, v_in, 1'b1);
                chk($sformatf("m%0d_idle%0d_%0d", s, t, c), 1'b0, exp_h[t], 7'd50, 7'd50, 1'b0);
            end
        end
    endtask

    initial begin
        //    sost h    s    v    rdy  valid hue  sat  val  err
        addv(0, 0,   0,   0,  1,   1, 120, 100, 100, 0);
        addv(0, 0,   0,   0,  1,   0, 120, 100, 100, 0);
        addv(3, 400, 0,   0,  1,   0, 120, 100, 100, 0);
        addv(3, 400, 0,   0,  1,   1, 359, 100, 100, 0);
        addv(3, 400, 0,   0,  1,   0, 359, 100, 100, 0);
        addv(4, 400, 0,   70, 1,   0, 359, 100, 100, 0);
        addv(4, 400, 0,   70, 1,   1, 359, 100, 70,  0);
        addv(4, 400, 0,   70, 1,   0, 359, 100, 70,  0);
        addv(5, 400, 40,  70, 1,   0, 359, 100, 70,  0);
        addv(5, 400, 40,  70, 1,   1, 359, 40,  70,  0);
        addv(5, 400, 127, 70, 1,   0, 359, 40,  70,  0);
        addv(5, 400, 127, 70, 1,   0, 359, 40,  70,  0);
        addv(5, 400, 127, 70, 1,   0, 359, 40,  70,  0);
        addv(5, 400, 127, 70, 1,   1, 359, 100, 70,  0);
        addv(6, 400, 127, 70, 1,   0, 359, 100, 70,  0);
        addv(6, 400, 127, 70, 1,   1, 359, 50,  50,  0);
        addv(0, 400, 127, 70, 1,   0, 359, 50,  50,  0);
        addv(0, 400, 127, 70, 1,   1, 120, 50,  50,  0);
        for (int i = 0; i < 5; i++)
            addv(9, 400, 127, 70, 1, 0, 120, 50, 50, 1);

        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #2 chk("reset_state", 1'b0, 9'd120, 7'd100, 7'd100, 1'b0);
        #4 reset_n = 1'b1;

        foreach (vq[i]) begin
            step(vq[i].sost, vq[i].h, vq[i].s, vq[i].v, vq[i].rdy);
            chk($sformatf("vec%0d", i), vq[i].exp_valid, vq[i].exp_hue, vq[i].exp_sat,
                vq[i].exp_val, vq[i].exp_err);
        end

        // Mode 1: +60 per tick from 120, wrapping through 300 -> 0
        exp_h = '{9'd180, 9'd240, 9'd300, 9'd0, 9'd60, 9'd120};
        mode_ticks(4'd1, 9'd120, 6);
        step(1, h_in, s_in, v_in, 1'b1);
        chk("m1_trailing", 1'b1, 9'd180, 7'd50, 7'd50, 1'b0);

        // Preset hue 358 via mode 3, then mode 2 increments across the wrap
        step(3, 9'd358, s_in, v_in, 1'b1);
        chk("preset_entry", 1'b0, 9'd180, 7'd50, 7'd50, 1'b0);
        step(3, 9'd358, s_in, v_in, 1'b1);
        chk("preset_snap", 1'b1, 9'd358, 7'd50, 7'd50, 1'b0);
        exp_h[0] = 9'd359; exp_h[1] = 9'd0; exp_h[2] = 9'd1;
        mode_ticks(4'd2, 9'd358, 3);

        // Backpressure: first snapshot (2) frozen while ticks advance work to 5
        step(2, h_in, s_in, v_in, 1'b0);
        chk("bp_first", 1'b1, 9'd2, 7'd50, 7'd50, 1'b0);
        for (int c = 0; c < 12; c++) begin
            step(2, h_in, s_in, v_in, 1'b0);
            chk($sformatf("bp_hold%0d", c), 1'b1, 9'd2, 7'd50, 7'd50, 1'b0);
        end
        step(2, h_in, s_in, v_in, 1'b1);
        chk("bp_coalesced", 1'b1, 9'd5, 7'd50, 7'd50, 1'b0);
        step(2, h_in, s_in, v_in, 1'b1);
        chk("bp_drain", 1'b0, 9'd5, 7'd50, 7'd50, 1'b0);

        // In-flight snapshot dropped by an asynchronous reset mid-cycle
        step(3, 9'd200, s_in, v_in, 1'b1);
        chk("rst_pre_entry", 1'b0, 9'd5, 7'd50, 7'd50, 1'b0);
        step(3, 9'd200, s_in, v_in, 1'b1);
        chk("rst_pre_snap", 1'b1, 9'd200, 7'd50, 7'd50, 1'b0);
        #1 reset_n = 1'b0;
        #1 chk("rst_async", 1'b0, 9'd120, 7'd100, 7'd100, 1'b0);
        sost = 4'd0;
        #1 reset_n = 1'b1;
        step(0, h_in, s_in, v_in, 1'b1);
        chk("rst_republish", 1'b1, 9'd120, 7'd100, 7'd100, 1'b0);
        step(0, h_in, s_in, v_in, 1'b1);
        chk("rst_idle", 1'b0, 9'd120, 7'd100, 7'd100, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
